// File: rtl/dro_pulse_framer.sv
// rtl/dro_pulse_framer.sv - toggle-to-pulse capture, frame packing and per-lane pulse counting for DRO outputs
module dro_pulse_framer #(
    parameter int LANES = 2,
    parameter int FRAME = 8,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         pulse_in,
    input  logic                     en,
    output logic [LANES*FRAME-1:0]   frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [LANES*CNT_W-1:0]   pulse_cnt,
    output logic                     overflow
);

    localparam int              BW      = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [BW-1:0]   LAST    = BW'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {PAUSE, FILL} mode_e;

    logic [LANES-1:0]       q1_q, q2_q, det_q;
    logic [BW-1:0]          beat_q, beat_d;
    logic [LANES*FRAME-1:0] asm_q, asm_d;
    logic [LANES*FRAME-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic [LANES*CNT_W-1:0] cnt_q, cnt_d;
    mode_e                  mode;
    logic                   complete;

    // Both synchronizer stages load the live input on reset so no edge is seen on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q    <= pulse_in;
            q2_q    <= pulse_in;
            det_q   <= '0;
            beat_q  <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            q1_q    <= pulse_in;
            q2_q    <= q1_q;
            det_q   <= q1_q ^ q2_q;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mode     = en ? FILL : PAUSE;
        beat_d   = beat_q;
        asm_d    = asm_q;
        complete = 1'b0;
        case (mode)
            FILL: begin
                for (int b = 0; b < FRAME; b++) begin
                    if (beat_q == BW'(b)) begin
                        asm_d[b*LANES +: LANES] = det_q;
                    end
                end
                complete = (beat_q == LAST);
                beat_d   = complete ? '0 : beat_q + BW'(1);
            end
            default: begin
            end
        endcase
    end

    // A completed word never overwrites a pending one unless that word is accepted on the same edge.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (complete) begin
            if (!valid_q || frame_ready) begin
                data_d  = asm_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < LANES; i++) begin
            if (det_q[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign pulse_cnt   = cnt_q;
    assign overflow    = ovf_q;

endmodule
